// File: rtl/global_defs.sv
// Shared request types passed between the command parser and the request queue.
// The parser output is 106 bits packed: 64 + 2 + 32 + 7 + 1.
package global_defs;

  localparam int ADDRESS_WIDTH = 32;

  typedef enum logic [1:0] {
    NOP   = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    FLUSH = 2'b11
  } parsed_op_t;

  typedef struct packed {
    logic [63:0]              CPU_clock_count;
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [6:0]               life;
    logic                     op_ready_s;
  } parser_out_struct;

endpackage

// File: rtl/request_queue_if.sv
// Handshake bundle between the parser, the request queue and the DRAM scheduler.
// The slave modport is the queue side; the master modport is the parser/scheduler side.
interface request_queue_if
  import global_defs::*;
#(
  parameter int QUEUE_DEPTH = 16
);

  parser_out_struct             in_req;
  logic                         q_full;
  logic                         q_empty;
  logic [$clog2(QUEUE_DEPTH):0] q_count;
  parser_out_struct             out_req;
  logic                         out_valid;
  logic                         out_ready;
  logic                         head_stale;
  logic                         overflow;

  modport slave (
    input  in_req,
    input  out_ready,
    output q_full,
    output q_empty,
    output q_count,
    output out_req,
    output out_valid,
    output head_stale,
    output overflow
  );

  modport master (
    output in_req,
    output out_ready,
    input  q_full,
    input  q_empty,
    input  q_count,
    input  out_req,
    input  out_valid,
    input  head_stale,
    input  overflow
  );

endinterface

// File: rtl/request_queue.sv
// Circular buffer of parsed requests feeding the DRAM scheduler, with per-entry
// age counters and a stale flag on the head entry.
module request_queue
  import global_defs::*;
#(
  parameter int QUEUE_DEPTH = 16,
  parameter int AGE_LIMIT   = 100
) (
  input logic             clk,
  input logic             rst_n,
  request_queue_if.slave  bus
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [6:0] LIFE_MAX = 7'd127;

  typedef struct packed {
    logic [63:0]              cpu_clock_count;
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
  } payload_t;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  payload_t      r_payload_mem [QUEUE_DEPTH];
  logic [6:0]    w_life        [QUEUE_DEPTH];

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_accept;
  logic          w_reject;
  payload_t      w_head_payload;
  logic [6:0]    w_head_life;
  parser_out_struct w_out_req;
  logic          w_unused_life;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(QUEUE_DEPTH));
  assign w_push   = bus.in_req.op_ready_s && (bus.in_req.opcode != NOP);
  assign w_pop    = !w_empty && bus.out_ready;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_reject = w_push && !w_accept;

  assign w_unused_life = ^bus.in_req.life;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_reject) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Payload needs no reset: occupancy decides whether a slot is meaningful.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_payload_mem[r_tail] <= '{
        cpu_clock_count: bus.in_req.CPU_clock_count,
        opcode:          bus.in_req.opcode,
        address:         bus.in_req.address
      };
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_life
      logic [PW-1:0] w_offset;
      logic          w_occupied;
      logic          w_write;
      logic [6:0]    r_life;

      assign w_offset   = PW'(gi) - r_head;
      assign w_occupied = ({1'b0, w_offset} < r_count);
      assign w_write    = w_accept && (r_tail == PW'(gi));

      // A freshly written slot restarts at zero; occupied slots age until saturation.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_life <= '0;
        end else if (w_write) begin
          r_life <= '0;
        end else if (w_occupied && (r_life != LIFE_MAX)) begin
          r_life <= r_life + 1'b1;
        end
      end

      assign w_life[gi] = r_life;
    end
  endgenerate

  assign w_head_payload = r_payload_mem[r_head];
  assign w_head_life    = w_life[r_head];

  always_comb begin
    w_out_req        = '0;
    w_out_req.opcode = NOP;
    if (!w_empty) begin
      w_out_req.CPU_clock_count = w_head_payload.cpu_clock_count;
      w_out_req.opcode          = w_head_payload.opcode;
      w_out_req.address         = w_head_payload.address;
      w_out_req.life            = w_head_life;
      w_out_req.op_ready_s      = 1'b1;
    end
  end

  assign bus.out_req    = w_out_req;
  assign bus.out_valid  = !w_empty;
  assign bus.q_empty    = w_empty;
  assign bus.q_full     = w_full;
  assign bus.q_count    = r_count;
  assign bus.head_stale = !w_empty && (w_head_life >= 7'(AGE_LIMIT));
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_request_queue.sv
// Directed and randomized bench for request_queue, checked every cycle against
// a queue-based reference model of the buffered requests and their ages.
module tb_request_queue;
  import global_defs::*;

  localparam int D   = 16;
  localparam int AGE = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  request_queue_if #(.QUEUE_DEPTH(D)) bus ();

  request_queue #(.QUEUE_DEPTH(D), .AGE_LIMIT(AGE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] cpu;
    parsed_op_t  op;
    logic [31:0] addr;
    int          life;
  } m_entry_t;

  m_entry_t    mq[$];
  bit          m_ovf;
  logic [31:0] pop_log[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic parser_out_struct exp_out();
    parser_out_struct e;
    e        = '0;
    e.opcode = NOP;
    if (mq.size() > 0) begin
      e.CPU_clock_count = mq[0].cpu;
      e.opcode          = mq[0].op;
      e.address         = mq[0].addr;
      e.life            = 7'(mq[0].life);
      e.op_ready_s      = 1'b1;
    end
    return e;
  endfunction

  task automatic check_all(input string tag);
    bit ne;
    ne = (mq.size() > 0);
    chk({tag, ".count"}, bus.q_count, mq.size());
    chk({tag, ".empty"}, bus.q_empty, !ne);
    chk({tag, ".full"},  bus.q_full, mq.size() == D);
    chk({tag, ".valid"}, bus.out_valid, ne);
    chk({tag, ".req"},   bus.out_req, exp_out());
    chk({tag, ".stale"}, bus.head_stale, ne && (mq[0].life >= AGE));
    chk({tag, ".ovf"},   bus.overflow, m_ovf);
  endtask

  task automatic model_update();
    bit pop, push, acc;
    m_entry_t e;
    pop  = (mq.size() > 0) && bus.out_ready;
    push = bus.in_req.op_ready_s && (bus.in_req.opcode != NOP);
    acc  = push && ((mq.size() < D) || pop);
    foreach (mq[i]) mq[i].life = (mq[i].life >= 127) ? 127 : mq[i].life + 1;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      e.cpu  = bus.in_req.CPU_clock_count;
      e.op   = bus.in_req.opcode;
      e.addr = bus.in_req.address;
      e.life = 0;
      mq.push_back(e);
    end
    if (push && !acc) m_ovf = 1'b1;
  endtask

  task automatic step(input string tag);
    if (bus.out_valid && bus.out_ready) pop_log.push_back(bus.out_req.address);
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  task automatic set_push(input parsed_op_t op, input logic [31:0] addr, input logic [63:0] cpu);
    bus.in_req.CPU_clock_count = cpu;
    bus.in_req.opcode          = op;
    bus.in_req.address         = addr;
    bus.in_req.life            = 7'($urandom);
    bus.in_req.op_ready_s      = 1'b1;
  endtask

  task automatic set_idle();
    bus.in_req.CPU_clock_count = {$urandom, $urandom};
    bus.in_req.opcode          = parsed_op_t'($urandom_range(0, 3));
    bus.in_req.address         = $urandom;
    bus.in_req.life            = 7'($urandom);
    bus.in_req.op_ready_s      = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int stale_at;
    set_idle();
    bus.out_ready = 1'b0;
    m_ovf = 1'b0;

    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single push on the first edge after reset, then watch it age.
    set_push(READ, 32'h1000, 64'd5);
    step("push1");
    chk("push1.addr", bus.out_req.address, 32'h1000);
    chk("push1.life", bus.out_req.life, 7'd0);
    set_idle();
    repeat (3) step("age3");
    chk("age3.life", bus.out_req.life, 7'd3);

    // Fill to capacity, then one more push is lost.
    for (int i = 1; i < D; i++) begin
      set_push(WRITE, 32'h2000 + i * 4, 64'(i));
      step("fill");
    end
    chk("fill.full", bus.q_full, 1'b1);
    chk("fill.count", bus.q_count, D);
    set_push(READ, 32'hDEAD0, 64'd77);
    step("ovf");
    chk("ovf.flag", bus.overflow, 1'b1);
    chk("ovf.head", bus.out_req.address, 32'h1000);

    // Full with simultaneous pop: the push is taken.
    do_reset("rst2");
    for (int i = 0; i < D; i++) begin
      set_push(WRITE, 32'h3000 + i * 4, 64'(i + 100));
      step("fill2");
    end
    set_push(READ, 32'hABCD0, 64'd99);
    bus.out_ready = 1'b1;
    step("fullpop");
    chk("fullpop.ovf", bus.overflow, 1'b0);
    chk("fullpop.count", bus.q_count, D);
    set_idle();
    repeat (D - 1) step("drain15");
    chk("fullpop.slot15", bus.out_req.address, 32'hABCD0);
    step("drainlast");

    // Ordering across pointer wrap.
    pop_log.delete();
    for (int i = 0; i < 20; i++) begin
      set_push(READ, 32'h4000 + i * 16, 64'(i));
      bus.out_ready = (i % 3 != 0);
      step("wrap");
    end
    set_idle();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && mq.size() > 0; k++) step("wrapdrain");
    chk("wrap.npop", pop_log.size(), 20);
    for (int i = 0; i < 20 && i < pop_log.size(); i++)
      chk($sformatf("wrap.order%0d", i), pop_log[i], 32'h4000 + i * 16);

    // Aging of a single held entry.
    bus.out_ready = 1'b0;
    set_push(WRITE, 32'h5000, 64'd7);
    step("agepush");
    set_idle();
    stale_at = -1;
    for (int c = 1; c <= 130; c++) begin
      step("aging");
      if (bus.head_stale && stale_at < 0) stale_at = c;
    end
    chk("aging.stale_rise", stale_at, AGE);
    chk("aging.sat", bus.out_req.life, 7'd127);

    // NOP with op_ready_s set is ignored.
    set_push(NOP, 32'h6000, 64'd1);
    step("nop");
    chk("nop.count", bus.q_count, 1);
    set_idle();

    // Randomized traffic, alternating push-heavy and pop-heavy phases.
    for (int k = 0; k < 3000; k++) begin
      bus.in_req.CPU_clock_count = {$urandom, $urandom};
      bus.in_req.opcode          = parsed_op_t'($urandom_range(0, 3));
      bus.in_req.address         = $urandom;
      bus.in_req.life            = 7'($urandom);
      bus.in_req.op_ready_s      = ($urandom_range(0, 3) != 0);
      bus.out_ready = ((k / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step("rand");
    end

    // Mid-operation reset with 5 entries held and overflow set.
    do_reset("rst3");
    bus.out_ready = 1'b0;
    for (int i = 0; i <= D; i++) begin
      set_push(READ, 32'h7000 + i * 4, 64'(i));
      step("fill3");
    end
    set_idle();
    bus.out_ready = 1'b1;
    repeat (D - 5) step("pop11");
    chk("pre_rst.count", bus.q_count, 5);
    do_reset("rst_mid");
    chk("rst_mid.empty", bus.q_empty, 1'b1);
    chk("rst_mid.op", bus.out_req.opcode, NOP);
    chk("rst_mid.ovf", bus.overflow, 1'b0);
    bus.out_ready = 1'b0;
    set_push(WRITE, 32'h8000, 64'd3);
    step("post_rst");
    set_idle();
    repeat (3) step("post_rst_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/request_queue.md
REQUEST_QUEUE -- requirements
Module: request_queue

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 16, number of buffered parsed requests; power of 2, 2..64.
REQ-002 SHALL have parameter AGE_LIMIT, default 100, life value at or above which the head is flagged stale; range 1..127.
REQ-003 SHALL take ADDRESS_WIDTH (32), parsed_op_t and parser_out_struct from global_defs; parser_out_struct is 106 bits packed.
REQ-004 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.
REQ-005 SHALL provide ports as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_req  in  parser_out_struct  request from parser; push requested when in_req.op_ready_s=1
- q_full  out  1  count==QUEUE_DEPTH; parser stalls while high
- q_empty  out  1  count==0
- q_count  out  $clog2(QUEUE_DEPTH)+1  entries held
- out_req  out  parser_out_struct  head entry
- out_valid  out  1  head entry present
- out_ready  in  1  consumer (DRAM scheduler) accepts head
- head_stale  out  1  out_valid and out_req.life>=AGE_LIMIT
- overflow  out  1  sticky, request lost

Function
REQ-006 SHALL implement a circular buffer: head and tail pointers that wrap from QUEUE_DEPTH-1 to 0, plus an occupancy counter.
REQ-007 SHALL define push = in_req.op_ready_s AND in_req.opcode!=NOP; a NOP with op_ready_s=1 SHALL be ignored, with no state change and no overflow.
REQ-008 SHALL define pop = out_valid AND out_ready.
REQ-009 SHALL accept a push when count<QUEUE_DEPTH, or when count==QUEUE_DEPTH and a pop occurs in the same cycle.
REQ-010 SHALL, on a push that is not accepted, discard the request, set overflow, and leave all entries unchanged.
REQ-011 SHALL, on an accepted push, write CPU_clock_count, opcode and address at tail, with life=0 and op_ready_s=1, then advance tail.
REQ-012 SHALL, on pop, advance head.
REQ-013 SHALL update count by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-014 SHALL make a pushed entry visible on out_req/out_valid the cycle after the push edge; there is no same-cycle bypass.
REQ-015 SHALL, on a simultaneous push and pop with count==1, present the new entry as head the next cycle.
REQ-016 SHALL, every cycle, increment life of every occupied entry by 1, saturating at 127; aging applies to entries not written this cycle.
REQ-017 SHALL hold the entry written in a given cycle at life=0 on the following cycle.
REQ-018 SHALL drive out_req from the head entry combinationally from registered storage.
REQ-019 SHALL, when count==0, drive out_req as opcode=NOP, address=0, CPU_clock_count=0, life=0, op_ready_s=0, and drive out_valid=0.
REQ-020 SHALL tie out_valid to !q_empty, and out_req.op_ready_s SHALL equal out_valid.
REQ-021 SHALL hold out_req stable while out_valid=1 and out_ready=0, except that life continues aging.
REQ-022 SHALL derive q_full, q_empty, q_count and head_stale from registered state only, with no combinational path from in_req or out_ready.
REQ-023 SHALL keep overflow sticky until reset.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear head, tail, count, overflow and all life fields.
REQ-025 SHALL drive outputs to q_empty=1, q_full=0, q_count=0, out_valid=0, head_stale=0, and out_req equal to the REQ-019 empty value during reset.
REQ-026 SHALL discard all buffered entries on a reset asserted mid-operation.
REQ-027 SHALL accept a push on the first rising edge after rst_n deasserts.

Verification
REQ-028 SHALL cover single push: push READ at addr 0x1000, count 5, out_ready=0 -> next cycle out_valid=1, out_req.address=0x1000, life=0; 3 cycles later life=3.
REQ-029 SHALL cover fill: 16 pushes, no pop -> q_full=1, q_count=16; a 17th push -> overflow=1, q_count=16, head unchanged.
REQ-030 SHALL cover full-with-pop: at count=16, push with out_ready=1 in the same cycle -> accepted, overflow=0, q_count=16, the new entry is at slot 15 relative to head.
REQ-031 SHALL cover ordering and wrap: 20 pushes interleaved with pops -> pop order equals push order across pointer wrap, and addresses match.
REQ-032 SHALL cover aging: hold a single entry 130 cycles -> life saturates at 127; head_stale rises exactly when life reaches 100.
REQ-033 SHALL cover NOP and reset: a NOP push leaves q_count unchanged; rst_n=0 with 5 entries held -> immediately q_empty=1, out_req.opcode=NOP, and overflow cleared.
